// File: rtl/gate_sweep_tester.sv
// Exhaustive gate tester: steps X through every input combination, holds each vector
// for SETTLE cycles plus one sample cycle, captures Y into RESP and compares against GOLDEN.
module gate_sweep_tester #(
    parameter int                      N_IN   = 4,
    parameter int                      SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]    GOLDEN = 16'h8000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   Y,
    output logic [N_IN-1:0]        X,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   PASS,
    output logic [(1<<N_IN)-1:0]   RESP
);

    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN:0] V_LAST = (N_IN+1)'(NV - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N_IN:0]   v_q, v_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] x_q, x_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [NV-1:0]   resp_q, resp_d;

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        resp_d  = resp_q;
        case (state_q)
            ST_IDLE: begin
                x_d = '0;
                if (START) begin
                    state_d = ST_SETTLE;
                    v_d     = '0;
                    cnt_d   = '0;
                    resp_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SAMPLE: begin
                resp_d[v_q[N_IN-1:0]] = Y;
                // PASS must see the bit captured on this same edge, hence resp_d.
                if (v_q == V_LAST) begin
                    state_d = ST_IDLE;
                    x_d     = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (resp_d == GOLDEN);
                end else begin
                    state_d = ST_SETTLE;
                    v_d     = v_q + (N_IN+1)'(1);
                    x_d     = v_q[N_IN-1:0] + N_IN'(1);
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            resp_q  <= resp_d;
        end
    end

    assign X    = x_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign PASS = pass_q;
    assign RESP = resp_q;

endmodule

// File: tb/tb_gate_sweep_tester.sv
// Directed bench: AND4/OR4/zero DUTs on two 4-input testers (different goldens),
// XOR2 on a 2-input tester; covers reset, timing, mid-sweep reset and START handling.
module tb_gate_sweep_tester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0;
    logic        start2 = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic [3:0]  x_a, x_b;
    logic [1:0]  x_c;
    logic        y_a, y_b, y_c;
    logic        busy_a, done_a, pass_a;
    logic        busy_b, done_b, pass_b;
    logic        busy_c, done_c, pass_c;
    logic [15:0] resp_a, resp_b;
    logic [3:0]  resp_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic gate_fn(input logic [1:0] s, input logic [3:0] x);
        case (s)
            2'd0:    return &x;
            2'd1:    return |x;
            default: return 1'b0;
        endcase
    endfunction

    assign y_a = gate_fn(sel, x_a);
    assign y_b = gate_fn(sel, x_b);
    assign y_c = x_c[0] ^ x_c[1];

    gate_sweep_tester #(.N_IN(4), .SETTLE(2), .GOLDEN(16'h8000)) u_dut_a (
        .CLK(clk), .RST(rst), .START(start4), .Y(y_a), .X(x_a),
        .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .RESP(resp_a));

    gate_sweep_tester #(.N_IN(4), .SETTLE(2), .GOLDEN(16'hFFFE)) u_dut_b (
        .CLK(clk), .RST(rst), .START(start4), .Y(y_b), .X(x_b),
        .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .RESP(resp_b));

    gate_sweep_tester #(.N_IN(2), .SETTLE(4), .GOLDEN(4'b0110)) u_dut_c (
        .CLK(clk), .RST(rst), .START(start2), .Y(y_c), .X(x_c),
        .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .RESP(resp_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the negedge inside cycle t+1 (t = cycle whose edge samples START).
    task automatic pulse_start(input bit use_c);
        @(negedge clk);
        if (use_c) start2 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    // n = cycle offset from t at which DONE is first seen; xerr counts wrong X vectors.
    task automatic run_sweep(input bit use_c, input bit repulse, output int n, output int xerr);
        int per;
        int exp_x;
        per  = use_c ? 5 : 3;
        n    = 1;
        xerr = 0;
        while (!(use_c ? done_c : done_a) && n <= 200) begin
            exp_x = (n - 1) / per;
            if (use_c ? (x_c != exp_x[1:0]) : (x_a != exp_x[3:0])) xerr++;
            if (repulse) start4 = (n == 5 || n == 30);
            @(negedge clk);
            n++;
        end
        if (repulse) start4 = 1'b0;
    endtask

    initial begin
        int n;
        int xerr;
        int hi;

        #12;
        check("rst_x",    32'(x_a),    0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_pass", 32'(pass_a), 0);
        check("rst_resp", 32'(resp_a), 0);
        check("rst_resp_c", 32'(resp_c), 0);
        @(negedge clk);
        rst = 1'b0;

        // AND4
        sel = 2'd0;
        pulse_start(1'b0);
        check("and_busy_t1", 32'(busy_a), 1);
        check("and_x_t1",    32'(x_a),    0);
        run_sweep(1'b0, 1'b0, n, xerr);
        check("and_done_cyc", n, 49);
        check("and_xseq",   xerr, 0);
        check("and_resp",   32'(resp_a), 32'h8000);
        check("and_pass",   32'(pass_a), 1);
        check("and_busy",   32'(busy_a), 0);
        check("and_x_idle", 32'(x_a),    0);
        check("and_pass_b", 32'(pass_b), 0);

        // OR4 against both goldens
        sel = 2'd1;
        pulse_start(1'b0);
        check("or_done_clr", 32'(done_a), 0);
        run_sweep(1'b0, 1'b0, n, xerr);
        check("or_done_cyc", n, 49);
        check("or_resp_b",  32'(resp_b), 32'hFFFE);
        check("or_pass_b",  32'(pass_b), 1);
        check("or_resp_a",  32'(resp_a), 32'hFFFE);
        check("or_pass_a",  32'(pass_a), 0);

        // XOR2, N_IN=2, SETTLE=4
        pulse_start(1'b1);
        check("xor_busy_t1", 32'(busy_c), 1);
        run_sweep(1'b1, 1'b0, n, xerr);
        check("xor_done_cyc", n, 21);
        check("xor_xseq",  xerr, 0);
        check("xor_resp",  32'(resp_c), 32'h6);
        check("xor_pass",  32'(pass_c), 1);

        // Y tied low
        sel = 2'd2;
        pulse_start(1'b0);
        run_sweep(1'b0, 1'b0, n, xerr);
        check("zero_resp", 32'(resp_a), 0);
        check("zero_pass", 32'(pass_a), 0);
        check("zero_done", 32'(done_a), 1);

        // Asynchronous reset at cycle 20 of an OR sweep: bits 0..5 captured so far
        sel = 2'd1;
        pulse_start(1'b0);
        repeat (19) @(negedge clk);
        check("abort_partial", 32'(resp_a), 32'h003E);
        #1 rst = 1'b1;
        #1;
        check("abort_x",    32'(x_a),    0);
        check("abort_busy", 32'(busy_a), 0);
        check("abort_done", 32'(done_a), 0);
        check("abort_resp", 32'(resp_a), 0);
        @(negedge clk);
        rst = 1'b0;
        sel = 2'd0;
        pulse_start(1'b0);
        run_sweep(1'b0, 1'b0, n, xerr);
        check("post_rst_cyc",  n, 49);
        check("post_rst_resp", 32'(resp_a), 32'h8000);
        check("post_rst_pass", 32'(pass_a), 1);

        // START re-pulsed mid-sweep is ignored
        pulse_start(1'b0);
        run_sweep(1'b0, 1'b1, n, xerr);
        check("repulse_cyc",  n, 49);
        check("repulse_xseq", xerr, 0);
        check("repulse_resp", 32'(resp_a), 32'h8000);

        // START held: restart on first IDLE cycle, DONE high for one cycle
        start4 = 1'b1;
        hi = 0;
        while (done_a && hi < 10) begin
            hi++;
            @(negedge clk);
        end
        check("held_done_width", hi, 1);
        check("held_busy", 32'(busy_a), 1);
        check("held_x",    32'(x_a),    0);
        start4 = 1'b0;
        run_sweep(1'b0, 1'b0, n, xerr);
        check("held_done_cyc", n, 49);
        check("held_resp", 32'(resp_a), 32'h8000);
        repeat (3) @(negedge clk);
        check("sticky_done", 32'(done_a), 1);
        check("sticky_pass", 32'(pass_a), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
